// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial feeder for the bit-serial adder: shifts two WIDTH-bit operands out LSB-first
// and drives the adder's carry-clear so every word starts with a zero carry.
module serial_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             carry_clr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           st;
    state_t           st_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             accept;

    // Accepting on the last bit lets the next word follow with no idle cycle.
    assign at_last  = (st == SHIFT) && (cnt == LAST_CNT);
    assign in_ready = rst & ((st == IDLE) | at_last);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
        end else begin
            st <= st_next;
        end
    end

    always_comb begin
        st_next   = st;
        a         = 1'b0;
        b         = 1'b0;
        bit_valid = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        carry_clr = 1'b1;
        case (st)
            IDLE: begin
                if (accept) begin
                    st_next = SHIFT;
                end
            end
            SHIFT: begin
                a         = sh_a[0];
                b         = sh_b[0];
                bit_valid = 1'b1;
                first     = (cnt == '0);
                last      = at_last;
                carry_clr = at_last;
                if (at_last && !accept) begin
                    st_next = IDLE;
                end
            end
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a <= '0;
            sh_b <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sh_a <= in_a;
            sh_b <= in_b;
            cnt  <= '0;
        end else if (st == SHIFT) begin
            if (at_last) begin
                cnt <= '0;
            end else begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: table vectors, corner sequences and a randomized run
// against a word-queue model, with a bit-serial adder model hanging off each instance.
module tb_serial_operand_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_ready, a, b, bit_valid, first, last, carry_clr;

    logic       in_valid_2;
    logic [1:0] in_a_2;
    logic [1:0] in_b_2;
    logic       in_ready_2, a_2, b_2, bit_valid_2, first_2, last_2, carry_clr_2;

    logic carry, carry_2, sum, sum_2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [7:0] exp_sum;
    } vec_t;

    typedef struct {
        logic [7:0] a, b, s, f, l, c, v, r;
    } word_t;

    typedef struct {
        logic a, b, f, l;
    } bit_t;

    always #5 clk = ~clk;

    serial_operand_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .a(a), .b(b), .bit_valid(bit_valid),
        .first(first), .last(last), .carry_clr(carry_clr)
    );

    serial_operand_serializer #(.WIDTH(2)) dut_2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_2), .in_a(in_a_2), .in_b(in_b_2),
        .in_ready(in_ready_2), .a(a_2), .b(b_2), .bit_valid(bit_valid_2),
        .first(first_2), .last(last_2), .carry_clr(carry_clr_2)
    );

    // Downstream bit-serial adders with synchronous carry clear.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry   <= 1'b0;
            carry_2 <= 1'b0;
        end else begin
            carry   <= carry_clr   ? 1'b0 : ((a & b) | (a & carry) | (b & carry));
            carry_2 <= carry_clr_2 ? 1'b0 : ((a_2 & b_2) | (a_2 & carry_2) | (b_2 & carry_2));
        end
    end
    assign sum   = a ^ b ^ carry;
    assign sum_2 = a_2 ^ b_2 ^ carry_2;

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] da, input logic [7:0] db);
        in_valid = v;
        in_a     = da;
        in_b     = db;
    endtask

    // Samples 8 bit-cycles starting at the current negedge; from index hold_from on, drives the next word.
    task automatic collectWord(input int hold_from, input logic nv, input logic [7:0] na,
                               input logic [7:0] nb, output word_t w);
        w.a = '0; w.b = '0; w.s = '0; w.f = '0; w.l = '0; w.c = '0; w.v = '0; w.r = '0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w.a[i] = a;
            w.b[i] = b;
            w.s[i] = sum;
            w.f[i] = first;
            w.l[i] = last;
            w.c[i] = carry_clr;
            w.v[i] = bit_valid;
            w.r[i] = in_ready;
            if (i == hold_from) applyStimulus(nv, na, nb);
            step();
        end
    endtask

    task automatic checkWord(input string tag, input word_t w, input logic [7:0] ea,
                             input logic [7:0] eb, input logic [7:0] es);
        checkOutput($sformatf("%s a bits", tag), 32'(w.a), 32'(ea));
        checkOutput($sformatf("%s b bits", tag), 32'(w.b), 32'(eb));
        checkOutput($sformatf("%s adder sum", tag), 32'(w.s), 32'(es));
        checkOutput($sformatf("%s first", tag), 32'(w.f), 32'h01);
        checkOutput($sformatf("%s last", tag), 32'(w.l), 32'h80);
        checkOutput($sformatf("%s carry_clr", tag), 32'(w.c), 32'h80);
        checkOutput($sformatf("%s bit_valid", tag), 32'(w.v), 32'hFF);
        checkOutput($sformatf("%s in_ready", tag), 32'(w.r), 32'h80);
    endtask

    initial begin
        vec_t       vecs[6];
        word_t      w1, w2;
        bit_t       q[$];
        logic [1:0] ra2, rb2, rs2, rf2, rl2, rv2;
        logic       drv_v, acc;
        logic [7:0] da, db;
        logic       exp_clr;

        vecs[0] = '{8'h5A, 8'h3C, 8'h96};
        vecs[1] = '{8'hFF, 8'h01, 8'h00};
        vecs[2] = '{8'h0F, 8'h01, 8'h10};
        vecs[3] = '{8'h01, 8'h01, 8'h02};
        vecs[4] = '{8'hAA, 8'h55, 8'hFF};
        vecs[5] = '{8'h80, 8'h80, 8'h00};

        applyStimulus(1'b0, 8'h00, 8'h00);
        in_valid_2 = 1'b0;
        in_a_2     = 2'b00;
        in_b_2     = 2'b00;
        rst        = 1'b1;
        #1 rst     = 1'b0;

        // Reset and idle behaviour.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset in_ready", 32'(in_ready), 32'h0);
            checkOutput("reset a/b", 32'({a, b}), 32'h0);
            checkOutput("reset bit_valid", 32'(bit_valid), 32'h0);
            checkOutput("reset first/last", 32'({first, last}), 32'h0);
            checkOutput("reset carry_clr", 32'(carry_clr), 32'h1);
            checkOutput("reset in_ready w2", 32'(in_ready_2), 32'h0);
        end
        rst = 1'b1;
        #1;
        checkOutput("post-reset in_ready", 32'(in_ready), 32'h1);
        checkOutput("post-reset bit_valid", 32'(bit_valid), 32'h0);
        checkOutput("post-reset carry_clr", 32'(carry_clr), 32'h1);
        @(negedge clk);

        // Table-driven single words.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].op_a, vecs[i].op_b);
            step();
            collectWord(99, 1'b0, 8'h00, 8'h00, w1);
            checkWord($sformatf("vec%0d", i), w1, vecs[i].op_a, vecs[i].op_b, vecs[i].exp_sum);
            checkOutput($sformatf("vec%0d idle bit_valid", i), 32'(bit_valid), 32'h0);
            checkOutput($sformatf("vec%0d idle in_ready", i), 32'(in_ready), 32'h1);
        end

        // Back-to-back words; the carry out of FF+01 must not reach the second word.
        applyStimulus(1'b1, 8'hFF, 8'h01);
        step();
        collectWord(7, 1'b1, 8'h0F, 8'h01, w1);
        collectWord(99, 1'b0, 8'h00, 8'h00, w2);
        checkWord("b2b word1", w1, 8'hFF, 8'h01, 8'h00);
        checkWord("b2b word2", w2, 8'h0F, 8'h01, 8'h10);

        // New word offered mid-word is held off until the last bit.
        applyStimulus(1'b1, 8'h5A, 8'h3C);
        step();
        collectWord(3, 1'b1, 8'h33, 8'h44, w1);
        collectWord(99, 1'b0, 8'h00, 8'h00, w2);
        checkWord("hold word1", w1, 8'h5A, 8'h3C, 8'h96);
        checkWord("hold word2", w2, 8'h33, 8'h44, 8'h77);

        // Asynchronous reset in the middle of a word.
        applyStimulus(1'b1, 8'h5A, 8'h3C);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        checkOutput("midreset pre a", 32'(a), 32'h1);
        checkOutput("midreset pre bit_valid", 32'(bit_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset in_ready", 32'(in_ready), 32'h0);
        checkOutput("midreset a/b", 32'({a, b}), 32'h0);
        checkOutput("midreset bit_valid", 32'(bit_valid), 32'h0);
        checkOutput("midreset first/last", 32'({first, last}), 32'h0);
        checkOutput("midreset carry_clr", 32'(carry_clr), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset release in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        applyStimulus(1'b1, 8'h01, 8'h01);
        step();
        collectWord(99, 1'b0, 8'h00, 8'h00, w1);
        checkWord("after midreset", w1, 8'h01, 8'h01, 8'h02);

        // WIDTH=2 instance.
        in_valid_2 = 1'b1;
        in_a_2     = 2'b10;
        in_b_2     = 2'b11;
        step();
        in_valid_2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ra2[i] = a_2;
            rb2[i] = b_2;
            rs2[i] = sum_2;
            rf2[i] = first_2;
            rl2[i] = last_2;
            rv2[i] = bit_valid_2;
            step();
        end
        checkOutput("w2 a bits", 32'(ra2), 32'h2);
        checkOutput("w2 b bits", 32'(rb2), 32'h3);
        checkOutput("w2 adder sum", 32'(rs2), 32'h1);
        checkOutput("w2 first", 32'(rf2), 32'h1);
        checkOutput("w2 last", 32'(rl2), 32'h2);
        checkOutput("w2 bit_valid", 32'(rv2), 32'h3);
        checkOutput("w2 idle bit_valid", 32'(bit_valid_2), 32'h0);

        // Randomized traffic against a queue of pending bits.
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_clr = (q.size() == 0) ? 1'b1 : q[0].l;
            checkOutput("rand in_ready", 32'(in_ready), 32'(q.size() <= 1));
            checkOutput("rand bit_valid", 32'(bit_valid), 32'(q.size() != 0));
            checkOutput("rand carry_clr", 32'(carry_clr), 32'(exp_clr));
            if (q.size() != 0) begin
                checkOutput("rand a/b", 32'({a, b}), 32'({q[0].a, q[0].b}));
                checkOutput("rand first/last", 32'({first, last}), 32'({q[0].f, q[0].l}));
            end else begin
                checkOutput("rand idle a/b", 32'({a, b}), 32'h0);
            end
            drv_v = ($urandom_range(0, 3) != 0);
            da    = 8'($urandom);
            db    = 8'($urandom);
            applyStimulus(drv_v, da, db);
            acc = drv_v && (q.size() <= 1);
            if (q.size() != 0) void'(q.pop_front());
            if (acc) begin
                for (int j = 0; j < 8; j++) q.push_back('{da[j], db[j], (j == 0), (j == 7)});
            end
            step();
        end
        applyStimulus(1'b0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
